// File: rtl/conv1d_obi_mgr.sv
// conv1d_obi_mgr: single-outstanding OBI burst manager bridging accelerator read/write streams
module conv1d_obi_mgr (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [15:0] cmd_len_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [31:0] wr_data_i,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [31:0] rd_data_o,
  output logic        obi_req_o,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_gnt_i,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  typedef enum logic [2:0] {IDLE, WDAT, REQ, RSP, RHOLD, DONE} state_t;
  state_t state, state_d;
  logic [15:0] cnt;
  logic [31:0] addr, wdata;
  logic we, last;
  assign last = cnt == 16'd1;
  assign cmd_ready_o = state == IDLE;
  assign wr_ready_o = state == WDAT;
  assign obi_req_o = state == REQ;
  assign rd_valid_o = state == RHOLD;
  assign done_o = state == DONE;
  assign busy_o = state != IDLE;
  assign obi_addr_o = addr;
  assign obi_wdata_o = wdata;
  assign obi_we_o = we;
  assign obi_be_o = 4'hF;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cmd_valid_i) state_d = cmd_len_i == 16'd0 ? DONE : cmd_we_i ? WDAT : REQ;
      WDAT:    if (wr_valid_i) state_d = REQ;
      REQ:     if (obi_gnt_i) state_d = RSP;
      RSP:     if (obi_rvalid_i) state_d = obi_err_i || (we && last) ? DONE : we ? WDAT : RHOLD;
      RHOLD:   if (rd_ready_i) state_d = last ? DONE : REQ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      we <= 1'b0;
      rd_data_o <= '0;
      err_o <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid_i) begin
        addr <= cmd_addr_i & 32'hFFFF_FFFC;
        we <= cmd_we_i;
        cnt <= cmd_len_i;
        err_o <= 1'b0;
      end
      if (state == WDAT && wr_valid_i) wdata <= wr_data_i;
      if (state == RSP && obi_rvalid_i) begin
        if (obi_err_i) err_o <= 1'b1;
        else if (we) begin
          cnt <= cnt - 16'd1;
          addr <= addr + 32'd4;
        end else rd_data_o <= obi_rdata_i;
      end
      if (state == RHOLD && rd_ready_i) begin
        cnt <= cnt - 16'd1;
        addr <= addr + 32'd4;
      end
    end
endmodule

// File: tb/tb_conv1d_obi_mgr.sv
// tb_conv1d_obi_mgr: randomized OBI slave + stream agents checked against a burst-level reference model
module tb_conv1d_obi_mgr;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic cmd_valid_i = 1'b0, cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic wr_valid_i = 1'b0, rd_ready_i = 1'b0;
  logic [31:0] wr_data_i = '0, obi_rdata_i = '0;
  logic obi_gnt_i = 1'b0, obi_rvalid_i = 1'b0, obi_err_i = 1'b0;
  logic cmd_ready_o, wr_ready_o, rd_valid_o, obi_req_o, obi_we_o, busy_o, done_o, err_o;
  logic [31:0] rd_data_o, obi_addr_o, obi_wdata_o;
  logic [3:0] obi_be_o;
  int checks = 0, errors = 0;
  bit noise = 1'b0;
  bit [31:0] mem [bit [31:0]];
  logic [31:0] g_addr[$], g_wdata[$], rd_beats[$], wq[$];
  logic g_we[$];
  int first_req_cyc, first_rd_cyc, done_cyc, busy_cycles, done_pulses;
  logic err_after_accept;

  conv1d_obi_mgr dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .obi_err_i(obi_err_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    cmd_valid_i = 0; wr_valid_i = 0; rd_ready_i = 0;
    obi_gnt_i = 0; obi_rvalid_i = 0; obi_err_i = 0;
  endtask

  task automatic burst(input logic we, input logic [31:0] addr, input int len,
                       input int gstall, input int ebeat, input int rstall);
    int c = 0, gcnt = 0, rcnt = 0, beat = 0, widx = 0;
    logic pend = 0, held = 0, req_prev = 0, gnt_prev = 0, pwe = 0, rwe = 0;
    logic [31:0] paddr = 0, pwdata = 0, ra = 0, rw = 0, hold_data = 0;
    g_addr.delete(); g_wdata.delete(); g_we.delete(); rd_beats.delete();
    first_req_cyc = -1; first_rd_cyc = -1; done_cyc = -1; busy_cycles = 0; done_pulses = 0;
    err_after_accept = 1'bx;
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready_o);
    end
    cmd_valid_i = 1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = 16'(len);
    while (c < 400) begin
      cyc();
      c++;
      cmd_valid_i = 1; cmd_we_i = 1'($urandom); cmd_addr_i = $urandom; cmd_len_i = 16'($urandom);
      if (c == 1) err_after_accept = err_o;
      if (busy_o) busy_cycles++;
      if (done_o) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (obi_req_o) begin
        checks++;
        if (obi_be_o !== 4'hF || rd_valid_o !== 1'b0) begin
          errors++; $display("FAIL req_be_excl: be %h rd_valid %b want F 0", obi_be_o, rd_valid_o);
        end
      end
      if (obi_req_o && req_prev && !gnt_prev) begin
        checks++;
        if (obi_addr_o !== ra || obi_wdata_o !== rw || obi_we_o !== rwe) begin
          errors++;
          $display("FAIL a_stable: got %h/%h/%b want %h/%h/%b", obi_addr_o, obi_wdata_o, obi_we_o, ra, rw, rwe);
        end
      end else if (obi_req_o) begin
        ra = obi_addr_o; rw = obi_wdata_o; rwe = obi_we_o;
      end
      if (rd_valid_o && held) begin
        checks++;
        if (rd_data_o !== hold_data) begin
          errors++; $display("FAIL rd_stable: got %h want %h", rd_data_o, hold_data);
        end
      end
      obi_rvalid_i = pend; obi_err_i = 0; obi_rdata_i = $urandom;
      if (pend) begin
        obi_err_i = beat == ebeat;
        if (!pwe) obi_rdata_i = mem_at(paddr);
        else if (!obi_err_i) mem[paddr] = pwdata;
        beat++;
      end else if (noise) begin
        obi_rvalid_i = 1'($urandom_range(0, 3) == 0);
        obi_err_i = 1'($urandom);
      end
      pend = 0;
      obi_gnt_i = noise && !obi_req_o ? 1'($urandom) : 1'b0;
      if (obi_req_o) begin
        if (first_req_cyc < 0) first_req_cyc = c;
        if (gcnt == gstall) begin
          obi_gnt_i = 1; gcnt = 0; pend = 1;
          paddr = obi_addr_o; pwdata = obi_wdata_o; pwe = obi_we_o;
          g_addr.push_back(obi_addr_o); g_wdata.push_back(obi_wdata_o); g_we.push_back(obi_we_o);
        end else gcnt++;
      end
      rd_ready_i = noise && !rd_valid_o ? 1'($urandom) : 1'b0;
      if (rd_valid_o) begin
        if (first_rd_cyc < 0) first_rd_cyc = c;
        if (!held) begin
          hold_data = rd_data_o; rcnt = 0;
        end
        if (rcnt >= rstall) begin
          rd_ready_i = 1; rd_beats.push_back(rd_data_o); held = 0;
        end else begin
          rcnt++; held = 1;
        end
      end else held = 0;
      wr_valid_i = noise && !wr_ready_o ? 1'($urandom) : 1'b0;
      wr_data_i = $urandom;
      if (wr_ready_o) begin
        wr_valid_i = 1;
        wr_data_i = widx < wq.size() ? wq[widx] : 32'hDEAD_BEEF;
        widx++;
      end
      req_prev = obi_req_o; gnt_prev = obi_gnt_i;
      if (done_o) break;
    end
    if (c >= 400) begin
      checks++; errors++; $display("FAIL burst_timeout: no done_o within %0d cycles", c);
    end
    quiet();
    cyc();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL post_idle: done %b busy %b ready %b want 0 0 1", done_o, busy_o, cmd_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 0; quiet();
    cyc(); cyc();
    checks++;
    if ({obi_req_o, obi_we_o, obi_be_o, rd_valid_o, wr_ready_o, done_o, busy_o, err_o} !== 11'b0011110_0000 ||
        obi_addr_o !== 0 || rd_data_o !== 0 || obi_wdata_o !== 0) begin
      errors++;
      $display("FAIL reset_vals: req %b we %b be %h rdv %b wrr %b done %b busy %b err %b addr %h rd %h wd %h",
               obi_req_o, obi_we_o, obi_be_o, rd_valid_o, wr_ready_o, done_o, busy_o, err_o,
               obi_addr_o, rd_data_o, obi_wdata_o);
    end
    rst_ni = 1;
    cyc();
    checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready %b busy %b want 1 0", cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_read();
    logic [31:0] exp[$];
    for (int i = 0; i < 3; i++) exp.push_back(mem_at(32'h1000_0000 + 32'(4 * i)));
    burst(0, 32'h1000_0000, 3, 0, -1, 0);
    checks++;
    if (g_addr.size() != 3 || rd_beats.size() != 3) begin
      errors++; $display("FAIL read_count: reqs %0d beats %0d want 3 3", g_addr.size(), rd_beats.size());
    end else for (int i = 0; i < 3; i++) begin
      checks++;
      if (g_addr[i] !== 32'h1000_0000 + 32'(4 * i) || rd_beats[i] !== exp[i] || g_we[i] !== 1'b0) begin
        errors++;
        $display("FAIL read_beat%0d: addr %h data %h we %b want %h %h 0", i, g_addr[i], rd_beats[i], g_we[i],
                 32'h1000_0000 + 32'(4 * i), exp[i]);
      end
    end
    checks++;
    if (first_req_cyc != 1 || first_rd_cyc != 3 || done_cyc != 10) begin
      errors++;
      $display("FAIL read_latency: req %0d rd %0d done %0d want 1 3 10", first_req_cyc, first_rd_cyc, done_cyc);
    end
    checks++;
    if (done_pulses != 1 || err_o !== 1'b0) begin
      errors++; $display("FAIL read_done_err: pulses %0d err %b want 1 0", done_pulses, err_o);
    end
  endtask

  task automatic test_write();
    wq = '{32'hA5A5_0001, 32'hA5A5_0002};
    burst(1, 32'h0000_0020, 2, 2, -1, 0);
    checks++;
    if (g_addr.size() != 2) begin
      errors++; $display("FAIL write_count: reqs %0d want 2", g_addr.size());
    end else for (int i = 0; i < 2; i++) begin
      checks++;
      if (g_addr[i] !== 32'h20 + 32'(4 * i) || g_wdata[i] !== wq[i] || g_we[i] !== 1'b1) begin
        errors++;
        $display("FAIL write_beat%0d: addr %h wdata %h we %b want %h %h 1", i, g_addr[i], g_wdata[i], g_we[i],
                 32'h20 + 32'(4 * i), wq[i]);
      end
    end
    checks++;
    if (mem[32'h20] !== 32'hA5A5_0001 || mem[32'h24] !== 32'hA5A5_0002 || done_pulses != 1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL write_mem: %h %h pulses %0d err %b want a5a50001 a5a50002 1 0",
               mem[32'h20], mem[32'h24], done_pulses, err_o);
    end
  endtask

  task automatic test_len0();
    burst(1'($urandom), $urandom, 0, 0, -1, 0);
    checks++;
    if (g_addr.size() != 0 || first_req_cyc != -1 || done_cyc != 1 || busy_cycles != 1 || done_pulses != 1) begin
      errors++;
      $display("FAIL len0: reqs %0d done_cyc %0d busy %0d pulses %0d want 0 1 1 1",
               g_addr.size(), done_cyc, busy_cycles, done_pulses);
    end
  endtask

  task automatic test_error();
    logic [31:0] a, d0;
    a = 32'h0000_4000;
    d0 = mem_at(a);
    burst(0, a | 32'h3, 4, 0, 1, 0);
    checks++;
    if (rd_beats.size() != 1 || g_addr.size() != 2 || err_o !== 1'b1 || done_pulses != 1) begin
      errors++;
      $display("FAIL err_abort: beats %0d reqs %0d err %b pulses %0d want 1 2 1 1",
               rd_beats.size(), g_addr.size(), err_o, done_pulses);
    end else begin
      checks++;
      if (rd_beats[0] !== d0 || g_addr[0] !== a) begin
        errors++; $display("FAIL err_beat0: data %h addr %h want %h %h", rd_beats[0], g_addr[0], d0, a);
      end
    end
    burst(0, 32'h0000_5000, 1, 0, -1, 0);
    checks++;
    if (err_after_accept !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL err_clear: after accept %b end %b want 0 0", err_after_accept, err_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d0, d1;
    d0 = mem_at(32'hFFFF_FFFC); d1 = mem_at(32'h0);
    burst(0, 32'hFFFF_FFFC, 2, 0, -1, 5);
    checks++;
    if (g_addr.size() != 2 || rd_beats.size() != 2) begin
      errors++; $display("FAIL wrap_count: reqs %0d beats %0d want 2 2", g_addr.size(), rd_beats.size());
    end else begin
      checks++;
      if (g_addr[0] !== 32'hFFFF_FFFC || g_addr[1] !== 32'h0 || rd_beats[0] !== d0 || rd_beats[1] !== d1) begin
        errors++;
        $display("FAIL wrap_beats: %h %h %h %h want fffffffc 0 %h %h", g_addr[0], g_addr[1], rd_beats[0], rd_beats[1], d0, d1);
      end
    end
    checks++;
    if (done_cyc != 17) begin
      errors++; $display("FAIL wrap_timing: done_cyc %0d want 17", done_cyc);
    end
  endtask

  task automatic test_mid_reset();
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: got %b want 1", cmd_ready_o);
    end
    cmd_valid_i = 1; cmd_we_i = 0; cmd_addr_i = 32'h0000_8000; cmd_len_i = 3;
    cyc();
    cmd_valid_i = 0;
    checks++;
    if (obi_req_o !== 1'b1) begin
      errors++; $display("FAIL midrst_req: got %b want 1", obi_req_o);
    end
    obi_gnt_i = 1;
    cyc();
    obi_gnt_i = 0;
    rst_ni = 0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({obi_req_o, obi_we_o, obi_be_o, rd_valid_o, wr_ready_o, done_o, busy_o, err_o, cmd_ready_o} !== 12'b0011110_00001 ||
          obi_addr_o !== 0 || rd_data_o !== 0) begin
        errors++;
        $display("FAIL midrst_vals%0d: req %b be %h rdv %b done %b busy %b err %b ready %b addr %h rd %h",
                 k, obi_req_o, obi_be_o, rd_valid_o, done_o, busy_o, err_o, cmd_ready_o, obi_addr_o, rd_data_o);
      end
      rst_ni = 1;
      obi_rvalid_i = k == 0; obi_err_i = k == 1; obi_rdata_i = $urandom;
      cyc();
    end
    quiet();
  endtask

  task automatic test_random();
    noise = 1;
    for (int t = 0; t < 25; t++) begin
      logic we;
      logic [31:0] base;
      int len, ebeat, n;
      logic [31:0] exp_rd[$];
      bit e;
      we = 1'($urandom); base = $urandom; len = $urandom_range(0, 5);
      ebeat = $urandom_range(0, 3) == 0 ? $urandom_range(0, 4) : -1;
      e = ebeat >= 0 && ebeat < len;
      n = e ? ebeat + 1 : len;
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back($urandom);
      for (int i = 0; i < n - int'(e); i++) exp_rd.push_back(mem_at((base & 32'hFFFF_FFFC) + 32'(4 * i)));
      burst(we, base, len, $urandom_range(0, 2), ebeat, $urandom_range(0, 3));
      checks++;
      if (g_addr.size() != n || done_pulses != 1 || err_o !== e || (!we && rd_beats.size() != exp_rd.size())) begin
        errors++;
        $display("FAIL rand%0d_shape: reqs %0d pulses %0d err %b beats %0d want %0d 1 %b %0d",
                 t, g_addr.size(), done_pulses, err_o, rd_beats.size(), n, e, we ? 0 : exp_rd.size());
        continue;
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (g_addr[i] !== (base & 32'hFFFF_FFFC) + 32'(4 * i) || g_we[i] !== we || (we && g_wdata[i] !== wq[i])) begin
          errors++;
          $display("FAIL rand%0d_req%0d: addr %h we %b wd %h want %h %b %h", t, i, g_addr[i], g_we[i], g_wdata[i],
                   (base & 32'hFFFF_FFFC) + 32'(4 * i), we, wq[i]);
        end
      end
      if (!we) for (int i = 0; i < exp_rd.size(); i++) begin
        checks++;
        if (rd_beats[i] !== exp_rd[i]) begin
          errors++; $display("FAIL rand%0d_rd%0d: got %h want %h", t, i, rd_beats[i], exp_rd[i]);
        end
      end
    end
    noise = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_len0();
    test_error();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv1d_obi_mgr.md
CONV1D_OBI_MGR -- requirements
Module: conv1d_obi_mgr

Interface
REQ-001 The block SHALL have no parameters: address and data are fixed at 32 bits, and the burst length is fixed at 16 bits.
REQ-002 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 cmd_valid_i  input  1  a transfer command is offered.
REQ-005 cmd_ready_o  output  1  the command is accepted when this and cmd_valid_i are both high.
REQ-006 cmd_we_i  input  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr_i  input  32  start byte address; bits [1:0] are ignored and treated as 0.
REQ-008 cmd_len_i  input  16  number of 32-bit words in the burst; 0 is legal.
REQ-009 wr_valid_i / wr_ready_o / wr_data_i  in / out / in  1 / 1 / 32  write-data stream from the accelerator.
REQ-010 rd_valid_o / rd_ready_i / rd_data_o  out / in / out  1 / 1 / 32  read-data stream to the accelerator.
REQ-011 obi_req_o, obi_addr_o[31:0], obi_we_o, obi_be_o[3:0], obi_wdata_o[31:0]  output  OBI manager A-channel.
REQ-012 obi_gnt_i, obi_rvalid_i, obi_rdata_i[31:0], obi_err_i  input  OBI manager R-channel and grant.
REQ-013 busy_o  output  1  high whenever the state is not IDLE.
REQ-014 done_o  output  1  one-cycle pulse when a burst completes or is aborted.
REQ-015 err_o  output  1  sticky bus-error flag; cleared when the next command is accepted.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, WDAT, REQ, RSP, RHOLD, DONE.
REQ-017 cmd_ready_o SHALL be high only in IDLE.
- On acceptance, the block SHALL latch the address (bits [1:0] forced to 0), the direction and the length.
- The beat counter SHALL be loaded with cmd_len_i.
REQ-018 From IDLE, on acceptance: if len = 0, go to DONE; else if write, go to WDAT; else go to REQ.
REQ-019 WDAT:
- wr_ready_o SHALL be high only in WDAT.
- On wr_valid_i, the data SHALL be captured into the wdata register and the state SHALL go to REQ.
REQ-020 REQ:
- obi_req_o = 1; obi_we_o = the latched direction; obi_be_o = 4'hF.
- obi_addr_o and obi_wdata_o SHALL come from registers.
- obi_req_o and all A-channel outputs SHALL remain stable until obi_gnt_i is sampled high.
- On grant, go to RSP.
REQ-021 Only one OBI transaction SHALL be outstanding at a time: obi_req_o SHALL be 0 in every state other than REQ.
REQ-022 RSP:
- obi_rvalid_i SHALL be acted on only in RSP; rvalid in any other state SHALL be ignored.
- On rvalid with obi_err_i = 1: set err_o, abandon the remaining beats, go to DONE; for a read, the erroring data SHALL NOT be presented.
- On rvalid, read, no error: capture obi_rdata_i into rd_data_o and go to RHOLD.
- On rvalid, write, no error: decrement the counter and advance the address by 4. If the counter reaches 0, go to DONE; else go to WDAT.
REQ-023 RHOLD:
- rd_valid_o = 1, and rd_data_o SHALL be held stable until rd_ready_i is sampled high.
- Then decrement the counter and advance the address by 4.
- If the counter reaches 0, go to DONE; else go to REQ.
REQ-024 DONE SHALL last one cycle with done_o = 1, then go to IDLE.
REQ-025 Address increments SHALL wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
REQ-026 Latency: with command accepted at edge k, gnt in the same cycle as req, and rvalid one cycle after gnt:
- obi_req_o is high in cycle k+1;
- rd_valid_o is high in cycle k+3;
- each further read beat adds 3 cycles when rd_ready_i is held high.
REQ-027 cmd_valid_i SHALL be ignored while busy_o is high; no command queueing.
REQ-028 busy_o, done_o, cmd_ready_o, wr_ready_o and rd_valid_o SHALL be driven directly from the registered state, with no combinational path from any input.

Reset
REQ-029 When rst_ni is sampled low, the block SHALL enter IDLE and clear the counter, address, wdata, rd_data_o and err_o to 0; this applies even mid-burst, including while a grant is pending.
REQ-030 Output values during and after reset:
- obi_req_o = 0, obi_we_o = 0, obi_be_o = 4'hF.
- rd_valid_o = 0, wr_ready_o = 0, done_o = 0, busy_o = 0.
- cmd_ready_o = 1 from the first cycle after reset is released.
REQ-031 A response arriving after a reset-aborted transaction SHALL be ignored (the state is IDLE).

Verification
REQ-032 Read burst: addr 0x1000_0000, len 3, gnt immediate, rvalid +1 cycle, rd_ready = 1 -> obi_addr sequence 0x1000_0000 / 0x1000_0004 / 0x1000_0008; three rd beats carrying the memory data; done_o pulses once; err_o = 0.
REQ-033 Write burst: addr 0x20, len 2, wr_data 0xA5A5_0001 then 0xA5A5_0002, with 2-cycle gnt stalls -> obi_we = 1; address and wdata stable through each stall; memory holds both words; done_o pulses once.
REQ-034 Length 0 -> no obi_req_o; done_o pulses in the cycle after acceptance; busy_o is high for exactly 1 cycle.
REQ-035 Error abort: read len 4 with obi_err_i on beat 2 -> exactly one rd beat delivered; err_o = 1; done_o pulses; err_o clears on the next command accept.
REQ-036 Back-pressure and wrap: read at addr 0xFFFF_FFFC, len 2, rd_ready held low for 5 cycles -> rd_data stable for those 5 cycles; second beat address = 0x0000_0000; no second obi_req_o until the first beat is consumed.
REQ-037 Mid-burst reset: assert rst_ni low during RSP of beat 1 of 3, then send a late rvalid -> all outputs at their reset values and the late rvalid ignored.
